// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage. Owns the architectural PC, issues
// instruction-memory requests with a req/ready handshake, and loads the IF/ID
// register. A word returned while the hazard unit stalls is parked in a hold
// buffer (HOLD state) and replayed later, so it is never fetched twice.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] npc,
  output logic [31:0] pc,
  input  logic        stall,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic        fetch_busy
);

  localparam logic [0:0] S_FETCH = 1'b0;
  localparam logic [0:0] S_HOLD  = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_q, hold_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_instr_q, id_instr_d;

  logic        in_fetch;
  logic        got_word;
  logic [31:0] word;
  logic [31:0] npc_aligned;

  assign in_fetch    = (state_q == S_FETCH);
  // In HOLD a word is always available (the parked one); in FETCH only on ready.
  assign got_word    = in_fetch ? imem_ready : 1'b1;
  assign word        = in_fetch ? imem_rdata : hold_q;
  assign npc_aligned = {npc[31:2], 2'b00};

  // Next-state: flush beats stall; a word is consumed on advance or parked on stall.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    hold_d     = hold_q;
    id_valid_d = id_valid_q;
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    if (flush) begin
      // Wrong-path word is dropped; PC only moves if a word actually completed,
      // so a flush during a memory wait keeps the outstanding address stable.
      id_valid_d = 1'b0;
      id_instr_d = 32'h0;
      state_d    = S_FETCH;
      if (got_word) pc_d = npc_aligned;
    end else if (got_word && !stall) begin
      id_valid_d = 1'b1;
      id_pc_d    = pc_q;
      id_instr_d = word;
      pc_d       = npc_aligned;
      state_d    = S_FETCH;
    end else if (got_word) begin
      hold_d  = word;
      state_d = S_HOLD;
    end else if (!stall) begin
      // Memory wait with downstream free: push a bubble, keep id_pc.
      id_valid_d = 1'b0;
      id_instr_d = 32'h0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      hold_q     <= 32'h0;
      id_valid_q <= 1'b0;
      id_pc_q    <= 32'h0;
      id_instr_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      hold_q     <= hold_d;
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
    end
  end

  // Request/busy are gated by reset so nothing is issued while reset is held.
  assign imem_req   = reset_n & in_fetch;
  assign fetch_busy = reset_n & in_fetch & ~imem_ready;
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign id_valid   = id_valid_q;
  assign id_pc      = id_pc_q;
  assign id_instr   = id_instr_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed test-plan sequence followed by randomized traffic,
// checked every cycle against a transaction-level model of the fetch stage.
module tb_fetch_stage;

  localparam logic [31:0] RPC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] npc;
  logic [31:0] pc;
  logic        stall, flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_pc, id_instr;
  logic        fetch_busy;

  fetch_stage #(.RESET_PC(RPC)) dut (
    .clk(clk), .reset_n(reset_n), .npc(npc), .pc(pc), .stall(stall), .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
    .fetch_busy(fetch_busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errs    = 0;

  // Reference model: PC, whether a received word is waiting downstream, IF/ID.
  bit          m_waiting;   // a word has been received but not yet delivered
  logic [31:0] m_word;
  logic [31:0] m_pc;
  bit          m_idv;
  logic [31:0] m_idpc, m_idi;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h3008) return 32'h2402_0005;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic model_reset();
    m_waiting = 0; m_word = 0; m_pc = RPC; m_idv = 0; m_idpc = 0; m_idi = 0;
  endtask

  // Called at a negedge: async reset pulse mid-cycle, outputs checked while low.
  task automatic do_reset();
    #3 reset_n = 1'b0;
    imem_ready = 1'b0;
    #1;
    model_reset();
    chk("rst_req",  imem_req,   0);
    chk("rst_busy", fetch_busy, 0);
    chk("rst_pc",   pc,         RPC);
    chk("rst_idv",  id_valid,   0);
    chk("rst_idpc", id_pc,      0);
    chk("rst_idi",  id_instr,   0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("first_req",  imem_req,  1);
    chk("first_addr", imem_addr, RPC);
  endtask

  // One clock cycle: drive at negedge, check comb outputs, then registers after edge.
  task automatic step(input bit st, input bit fl, input bit rdy, input logic [31:0] nx);
    bit got;
    logic [31:0] w;
    stall = st; flush = fl; imem_ready = rdy; npc = nx;
    imem_rdata = mem(m_pc);
    #1;
    chk("imem_req",   imem_req,   !m_waiting);
    chk("imem_addr",  imem_addr,  m_pc);
    chk("fetch_busy", fetch_busy, !m_waiting && !rdy);
    @(posedge clk);
    got = m_waiting || rdy;
    w   = m_waiting ? m_word : mem(m_pc);
    if (fl) begin
      m_idv = 0; m_idi = 0; m_waiting = 0;
      if (got) m_pc = nx & ~32'h3;
    end else if (got && !st) begin
      m_idv = 1; m_idpc = m_pc; m_idi = w; m_pc = nx & ~32'h3; m_waiting = 0;
    end else if (got) begin
      m_waiting = 1; m_word = w;
    end else if (!st) begin
      m_idv = 0; m_idi = 0;
    end
    #1;
    chk("pc",       pc,       m_pc);
    chk("id_valid", id_valid, m_idv);
    chk("id_pc",    id_pc,    m_idpc);
    chk("id_instr", id_instr, m_idi);
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; stall = 0; flush = 0; imem_ready = 0; npc = 0; imem_rdata = 0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Streaming, then two wait cycles at 0x3004.
    step(0, 0, 1, m_pc + 4);
    chk("pc_3004", pc, 32'h3004);
    step(0, 0, 0, m_pc + 4);
    chk("bubble1", id_valid, 0);
    step(0, 0, 0, m_pc + 4);
    chk("bubble2_addr", imem_addr, 32'h3004);
    step(0, 0, 1, m_pc + 4);
    // Stall on the 0x3008 response, hold three cycles, release.
    step(1, 0, 1, m_pc + 4);
    chk("hold_req", imem_req, 0);
    step(1, 0, 0, m_pc + 4);
    step(1, 0, 0, m_pc + 4);
    step(0, 0, 0, m_pc + 4);
    chk("replay_pc",    id_pc,    32'h3008);
    chk("replay_instr", id_instr, 32'h2402_0005);
    chk("replay_npc",   pc,       32'h300C);
    step(0, 0, 1, m_pc + 4);
    step(0, 0, 0, m_pc + 4);
    chk("wait_3010", pc, 32'h3010);
    do_reset();
    // Flush with stall while in HOLD.
    step(0, 0, 1, m_pc + 4);
    step(1, 0, 1, m_pc + 4);
    step(1, 1, 0, 32'h4000);
    chk("flush_pc",  pc,       32'h4000);
    chk("flush_idv", id_valid, 0);
    chk("flush_req", imem_req, 1);
    // Misaligned npc and wrap-around.
    step(0, 0, 1, 32'h3007);
    chk("align", pc, 32'h3004);
    step(0, 0, 1, 32'hFFFF_FFFC);
    step(0, 0, 1, m_pc + 4);
    chk("wrap", pc, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit st, fl, rdy;
      logic [31:0] nx;
      if ($urandom_range(0, 299) == 0) do_reset();
      rdy = ($urandom_range(0, 3) != 0);
      st  = ($urandom_range(0, 3) == 0);
      fl  = ($urandom_range(0, 15) == 0);
      nx  = ($urandom_range(0, 7) == 0) ? $urandom : m_pc + 4;
      step(st, fl, rdy, nx);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
